// File: rtl/cpu_addr_seq.sv
// 6502-style per-instruction bus sequencer: owns PC, fetches opcodes,
// and walks the addressing-mode cycles to form the effective address.
`ifndef ADR_IMPL
`define ADR_IMPL      5'd0
`define ADR_ACCUM     5'd1
`define ADR_IMM       5'd2
`define ADR_ZPG       5'd3
`define ADR_ZPG_X_Y   5'd4
`define ADR_ABS       5'd5
`define ADR_ABS_X_Y   5'd6
`define ADR_ZPG_X_IND 5'd7
`define ADR_ZPG_IND_Y 5'd8
`define ADR_REL       5'd9
`define ADR_ABS_JMP   5'd10
`define ADR_INVAL     5'd31
`define ADR_INDEX_Y   1'b1
`endif

module cpu_addr_seq #(
  parameter logic [15:0] RST_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [4:0]  adr_mode,
  input  logic        index,
  input  logic        to_mem,
  input  logic        branch_taken,
  input  logic [7:0]  reg_x,
  input  logic [7:0]  reg_y,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic        rw,
  output logic        sync,
  output logic        ir_load,
  output logic        exec,
  output logic [7:0]  operand,
  output logic [15:0] pc,
  output logic        inval
);

  typedef enum logic [3:0] {
    VEC_LO, VEC_HI, FETCH, T1, IDX, PLO, PHI,
    ADH, FIX, EXEC, BR, BFIX, TRAP
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc_n;
  logic [7:0]  operand_n;
  logic [7:0]  base, base_n;
  logic [7:0]  lo, lo_n;
  logic [7:0]  hi, hi_n;
  logic        c, c_n;
  logic        inval_q, inval_n;
  logic [7:0]  idx;
  logic [8:0]  sum;
  logic        mode_ok;

  assign idx = (index == `ADR_INDEX_Y) ? reg_y : reg_x;

  always_comb begin
    mode_ok = 1'b1;
    case (adr_mode)
      `ADR_IMPL, `ADR_ACCUM, `ADR_IMM, `ADR_ZPG,
      `ADR_ZPG_X_Y, `ADR_ABS, `ADR_ABS_X_Y,
      `ADR_ZPG_X_IND, `ADR_ZPG_IND_Y, `ADR_REL,
      `ADR_ABS_JMP: mode_ok = 1'b1;
      default:      mode_ok = 1'b0;
    endcase
  end

  assign inval = inval_q | (state == T1 && !mode_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= VEC_LO;
      pc      <= 16'h0000;
      operand <= 8'h00;
      base    <= 8'h00;
      lo      <= 8'h00;
      hi      <= 8'h00;
      c       <= 1'b0;
      inval_q <= 1'b0;
    end else if (rdy) begin
      state   <= state_n;
      pc      <= pc_n;
      operand <= operand_n;
      base    <= base_n;
      lo      <= lo_n;
      hi      <= hi_n;
      c       <= c_n;
      inval_q <= inval_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    operand_n = operand;
    base_n    = base;
    lo_n      = lo;
    hi_n      = hi;
    c_n       = c;
    inval_n   = inval_q;
    sum       = 9'd0;
    addr      = pc;
    rw        = 1'b1;
    sync      = 1'b0;
    ir_load   = 1'b0;
    exec      = 1'b0;
    unique case (state)
      VEC_LO: begin
        addr    = RST_VEC;
        pc_n    = {pc[15:8], data_in};
        state_n = VEC_HI;
      end
      VEC_HI: begin
        addr    = RST_VEC + 16'd1;
        pc_n    = {data_in, pc[7:0]};
        state_n = FETCH;
      end
      FETCH: begin
        sync    = 1'b1;
        ir_load = 1'b1;
        pc_n    = pc + 16'd1;
        state_n = T1;
      end
      T1: begin
        // zero-page modes start with hi=0 so EXEC can always use {hi,lo}
        operand_n = data_in;
        base_n    = data_in;
        lo_n      = data_in;
        hi_n      = 8'h00;
        pc_n      = pc + 16'd1;
        case (adr_mode)
          `ADR_IMPL, `ADR_ACCUM: begin
            operand_n = operand;
            base_n    = base;
            lo_n      = lo;
            hi_n      = hi;
            pc_n      = pc;
            exec      = 1'b1;
            state_n   = FETCH;
          end
          `ADR_IMM: begin
            exec    = 1'b1;
            state_n = FETCH;
          end
          `ADR_ZPG:       state_n = EXEC;
          `ADR_ZPG_X_Y:   state_n = IDX;
          `ADR_ZPG_X_IND: state_n = IDX;
          `ADR_ZPG_IND_Y: state_n = PLO;
          `ADR_ABS, `ADR_ABS_X_Y, `ADR_ABS_JMP:
            state_n = ADH;
          `ADR_REL: state_n = branch_taken ? BR : FETCH;
          default: begin
            operand_n = operand;
            base_n    = base;
            lo_n      = lo;
            hi_n      = hi;
            pc_n      = pc;
            inval_n   = 1'b1;
            state_n   = TRAP;
          end
        endcase
      end
      IDX: begin
        addr    = {8'h00, operand};
        base_n  = operand + idx;
        lo_n    = operand + idx;
        hi_n    = 8'h00;
        state_n = (adr_mode == `ADR_ZPG_X_IND) ? PLO : EXEC;
      end
      PLO: begin
        addr    = {8'h00, base};
        lo_n    = data_in;
        state_n = PHI;
      end
      PHI: begin
        addr    = {8'h00, base + 8'd1};
        hi_n    = data_in;
        state_n = EXEC;
        if (adr_mode == `ADR_ZPG_IND_Y) begin
          sum     = {1'b0, lo} + {1'b0, idx};
          lo_n    = sum[7:0];
          c_n     = sum[8];
          state_n = (sum[8] || to_mem) ? FIX : EXEC;
        end
      end
      ADH: begin
        hi_n    = data_in;
        lo_n    = operand;
        pc_n    = pc + 16'd1;
        state_n = EXEC;
        if (adr_mode == `ADR_ABS_JMP) begin
          pc_n    = {data_in, operand};
          state_n = FETCH;
        end else if (adr_mode == `ADR_ABS_X_Y) begin
          sum     = {1'b0, operand} + {1'b0, idx};
          lo_n    = sum[7:0];
          c_n     = sum[8];
          state_n = (sum[8] || to_mem) ? FIX : EXEC;
        end
      end
      FIX: begin
        addr    = {hi, lo};
        hi_n    = hi + {7'd0, c};
        state_n = EXEC;
      end
      EXEC: begin
        addr    = {hi, lo};
        rw      = ~to_mem;
        exec    = 1'b1;
        state_n = FETCH;
      end
      BR: begin
        // high byte moves only when carry disagrees with offset sign
        sum     = {1'b0, pc[7:0]} + {1'b0, operand};
        pc_n    = {pc[15:8], sum[7:0]};
        state_n = (sum[8] != operand[7]) ? BFIX : FETCH;
      end
      BFIX: begin
        pc_n[15:8] = operand[7] ? pc[15:8] - 8'd1
                                : pc[15:8] + 8'd1;
        state_n    = FETCH;
      end
      TRAP: begin
        state_n = TRAP;
      end
      default: state_n = TRAP;
    endcase
  end

endmodule

// File: tb/tb_cpu_addr_seq.sv
// Directed bench for cpu_addr_seq: small program in a byte memory,
// per-instruction bus traces checked against hand-computed cycles.
`ifndef ADR_IMPL
`define ADR_IMPL      5'd0
`define ADR_ACCUM     5'd1
`define ADR_IMM       5'd2
`define ADR_ZPG       5'd3
`define ADR_ZPG_X_Y   5'd4
`define ADR_ABS       5'd5
`define ADR_ABS_X_Y   5'd6
`define ADR_ZPG_X_IND 5'd7
`define ADR_ZPG_IND_Y 5'd8
`define ADR_REL       5'd9
`define ADR_ABS_JMP   5'd10
`define ADR_INVAL     5'd31
`define ADR_INDEX_Y   1'b1
`endif

module tb_cpu_addr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [4:0]  adr_mode;
  logic        index;
  logic        to_mem;
  logic        branch_taken;
  logic [7:0]  reg_x;
  logic [7:0]  reg_y;
  logic [7:0]  data_in;
  logic [15:0] addr;
  logic        rw;
  logic        sync;
  logic        ir_load;
  logic        exec;
  logic [7:0]  operand;
  logic [15:0] pc;
  logic        inval;

  logic [7:0]  mem [0:65535];
  logic [15:0] tr_addr [0:15];
  logic        tr_rw   [0:15];
  logic        tr_ex   [0:15];

  int n_chk = 0;
  int n_err = 0;
  int n;
  int wr_cnt;

  always #5 clk = ~clk;

  assign data_in = mem[addr];

  cpu_addr_seq #(.RST_VEC(16'hFFFC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .adr_mode(adr_mode), .index(index),
    .to_mem(to_mem), .branch_taken(branch_taken),
    .reg_x(reg_x), .reg_y(reg_y), .data_in(data_in),
    .addr(addr), .rw(rw), .sync(sync),
    .ir_load(ir_load), .exec(exec),
    .operand(operand), .pc(pc), .inval(inval)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts on a FETCH cycle (negedge), ends on the next FETCH.
  task automatic run_instr(input logic [4:0] m,
                           input logic iy, tm, bt,
                           input int s_at, s_len,
                           output int cyc);
    adr_mode     = m;
    index        = iy;
    to_mem       = tm;
    branch_taken = bt;
    cyc = 0;
    forever begin
      tr_addr[cyc] = addr;
      tr_rw[cyc]   = rw;
      tr_ex[cyc]   = exec;
      rdy = !(cyc >= s_at && cyc < s_at + s_len);
      cyc++;
      @(negedge clk);
      if (sync) break;
      if (cyc >= 15) begin
        chk("timeout", {31'd0, sync}, 32'd1);
        break;
      end
    end
    rdy = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hBD; mem[16'h8001] = 8'hF0;
    mem[16'h8002] = 8'h12;
    mem[16'h8003] = 8'hBD; mem[16'h8004] = 8'hF0;
    mem[16'h8005] = 8'h12;
    mem[16'h8006] = 8'h81; mem[16'h8007] = 8'hFF;
    mem[16'h8008] = 8'h91; mem[16'h8009] = 8'h40;
    mem[16'h800A] = 8'h4C; mem[16'h800B] = 8'hFD;
    mem[16'h800C] = 8'h80;
    mem[16'h80FD] = 8'hD0; mem[16'h80FE] = 8'h05;
    mem[16'h80FF] = 8'hEA;
    mem[16'h8100] = 8'hA5; mem[16'h8101] = 8'h77;
    mem[16'h8102] = 8'h02;
    mem[16'h8104] = 8'h4C; mem[16'h8105] = 8'hFD;
    mem[16'h8106] = 8'h80;
    mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h56;
    mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h20;

    rst_n = 1'b0; rdy = 1'b1;
    adr_mode = `ADR_IMPL; index = 1'b0;
    to_mem = 1'b0; branch_taken = 1'b0;
    reg_x = 8'h00; reg_y = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_addr", {16'd0, addr}, 32'hFFFC);
    chk("rst_rw", {31'd0, rw}, 32'd1);
    chk("rst_sync", {31'd0, sync}, 32'd0);
    chk("rst_exec", {31'd0, exec}, 32'd0);
    chk("rst_inval", {31'd0, inval}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'h0000);
    chk("rst_operand", {24'd0, operand}, 32'h00);

    rst_n = 1'b1;
    chk("vec_lo", {16'd0, addr}, 32'hFFFC);
    @(negedge clk);
    chk("vec_hi", {16'd0, addr}, 32'hFFFD);
    chk("vec_hi_sync", {31'd0, sync}, 32'd0);
    @(negedge clk);
    chk("fetch0_addr", {16'd0, addr}, 32'h8000);
    chk("fetch0_sync", {31'd0, sync}, 32'd1);
    chk("fetch0_irld", {31'd0, ir_load}, 32'd1);

    reg_x = 8'h20;
    run_instr(`ADR_ABS_X_Y, 1'b0, 1'b0, 1'b0, 99, 0, n);
    chk("absx_cross_cyc", n, 5);
    chk("absx_fix_addr", {16'd0, tr_addr[3]}, 32'h1210);
    chk("absx_fix_exec", {31'd0, tr_ex[3]}, 32'd0);
    chk("absx_ea", {16'd0, tr_addr[4]}, 32'h1310);
    chk("absx_exec", {31'd0, tr_ex[4]}, 32'd1);
    chk("absx_operand", {24'd0, operand}, 32'hF0);
    chk("absx_next", {16'd0, addr}, 32'h8003);

    reg_x = 8'h01;
    run_instr(`ADR_ABS_X_Y, 1'b0, 1'b0, 1'b0, 99, 0, n);
    chk("absx_nocross_cyc", n, 4);
    chk("absx_nocross_ea", {16'd0, tr_addr[3]}, 32'h12F1);
    chk("absx_nocross_exec", {31'd0, tr_ex[3]}, 32'd1);

    reg_x = 8'h00;
    run_instr(`ADR_ZPG_X_IND, 1'b0, 1'b1, 1'b0, 99, 0, n);
    chk("xind_cyc", n, 6);
    chk("xind_plo", {16'd0, tr_addr[3]}, 32'h00FF);
    chk("xind_phi_wrap", {16'd0, tr_addr[4]}, 32'h0000);
    chk("xind_ea", {16'd0, tr_addr[5]}, 32'h5634);
    chk("xind_rw", {31'd0, tr_rw[5]}, 32'd0);
    chk("xind_phi_rw", {31'd0, tr_rw[4]}, 32'd1);

    reg_y = 8'h10;
    run_instr(`ADR_ZPG_IND_Y, `ADR_INDEX_Y, 1'b1, 1'b0, 2, 3, n);
    chk("indy_stall_cyc", n, 9);
    chk("indy_stall_hold", {16'd0, tr_addr[5]}, 32'h0040);
    chk("indy_phi", {16'd0, tr_addr[6]}, 32'h0041);
    chk("indy_fix", {16'd0, tr_addr[7]}, 32'h2010);
    chk("indy_ea", {16'd0, tr_addr[8]}, 32'h2010);
    wr_cnt = 0;
    for (int i = 0; i < n; i++) if (!tr_rw[i]) wr_cnt++;
    chk("indy_wr_count", wr_cnt, 1);
    chk("indy_wr_exec", {31'd0, tr_rw[8]}, 32'd0);

    run_instr(`ADR_ABS_JMP, 1'b0, 1'b0, 1'b0, 99, 0, n);
    chk("jmp_cyc", n, 3);
    chk("jmp_pc", {16'd0, pc}, 32'h80FD);

    run_instr(`ADR_REL, 1'b0, 1'b0, 1'b1, 99, 0, n);
    chk("br_taken_cyc", n, 4);
    chk("br_bfix_addr", {16'd0, tr_addr[3]}, 32'h8004);
    chk("br_taken_pc", {16'd0, addr}, 32'h8104);

    run_instr(`ADR_ABS_JMP, 1'b0, 1'b0, 1'b0, 99, 0, n);
    mem[16'h80FE] = 8'hF0;
    run_instr(`ADR_REL, 1'b0, 1'b0, 1'b0, 99, 0, n);
    chk("br_not_cyc", n, 2);
    chk("br_not_pc", {16'd0, pc}, 32'h80FF);

    run_instr(`ADR_IMPL, 1'b0, 1'b0, 1'b0, 99, 0, n);
    chk("impl_cyc", n, 2);
    chk("impl_exec", {31'd0, tr_ex[1]}, 32'd1);
    chk("impl_next", {16'd0, addr}, 32'h8100);

    run_instr(`ADR_ZPG, 1'b0, 1'b0, 1'b0, 99, 0, n);
    chk("zpg_cyc", n, 3);
    chk("zpg_ea", {16'd0, tr_addr[2]}, 32'h0077);

    adr_mode = `ADR_INVAL;
    @(negedge clk);
    chk("inval_t1", {31'd0, inval}, 32'd1);
    chk("inval_t1_addr", {16'd0, addr}, 32'h8103);
    repeat (3) @(negedge clk);
    chk("trap_addr", {16'd0, addr}, 32'h8103);
    chk("trap_inval", {31'd0, inval}, 32'd1);
    chk("trap_sync", {31'd0, sync}, 32'd0);
    chk("trap_rw", {31'd0, rw}, 32'd1);

    adr_mode = `ADR_IMPL;
    rst_n = 1'b0;
    #1;
    chk("rerst_inval", {31'd0, inval}, 32'd0);
    chk("rerst_addr", {16'd0, addr}, 32'hFFFC);
    chk("rerst_pc", {16'd0, pc}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_vec_hi", {16'd0, addr}, 32'hFFFD);
    @(negedge clk);
    chk("rerst_fetch", {16'd0, addr}, 32'h8000);
    chk("rerst_sync", {31'd0, sync}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_addr_seq.md
Name: cpu_addr_seq

Overview:
- Per-instruction bus sequencer that sits directly downstream of the instruction decoder.
- Owns the PC and fetches the opcode, loading IR.
- Takes the decoder's `adr_mode`/`index` and steps the 6502 addressing cycles to produce the address bus, read/write and an execute strobe for the datapath.
- Supported modes: IMPL, ACCUM, IMM, ZPG, ZPG_X_Y, ABS, ABS_X_Y, ZPG_X_IND, ZPG_IND_Y, REL, ABS_JMP. All other modes trap.

Parameters:
- RST_VEC, 16'hFFFC, address of the reset vector low byte.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  0 = freeze all state and outputs this cycle
- adr_mode  in  5  decoder addressing mode, encoded with the `ADR_* macros from config.vh
- index  in  1  `ADR_INDEX_Y selects reg_y; otherwise reg_x
- to_mem  in  1  instruction writes memory in its exec cycle
- branch_taken  in  1  branch condition met; valid in the REL operand cycle
- reg_x  in  8  X register
- reg_y  in  8  Y register
- data_in  in  8  memory read data
- addr  out  16  address bus
- rw  out  1  1 = read, 0 = write
- sync  out  1  opcode fetch cycle
- ir_load  out  1  latch data_in into IR at end of this cycle
- exec  out  1  datapath executes this cycle; addr = effective address, or PC for IMPL/ACCUM/IMM
- operand  out  8  latched first operand byte
- pc  out  16  program counter
- inval  out  1  sticky trap flag

Behaviour:
- Reset (async, rst_n=0):
  - state=VEC_LO; addr=RST_VEC; rw=1; sync=ir_load=exec=inval=0; pc=0; operand=0.
- Startup:
  - VEC_LO reads RST_VEC → pc[7:0].
  - VEC_HI reads RST_VEC+1 → pc[15:8].
  - Then FETCH.
- Registering and stall:
  - All outputs are registered by state; addr is combinational from state and internal regs.
  - rdy=0 holds every register and output unchanged, including during write cycles.
- FETCH:
  - addr=pc, sync=1, ir_load=1, pc++.
  - Next state T1; `adr_mode` is valid from T1 onward.
- T1 (addr=pc), by mode:
  - IMPL/ACCUM: dummy read, no pc++, exec=1 → FETCH.
  - IMM: exec=1, pc++ → FETCH.
  - Any other mode: operand←data_in, pc++.
    - ZPG → EXEC.
    - ZPG_X_Y → IDX.
    - ABS/ABS_X_Y/ABS_JMP → ADH.
    - ZPG_X_IND → IDX.
    - ZPG_IND_Y → PLO.
    - REL → BR if branch_taken, else FETCH.
  - Invalid mode: inval=1, state TRAP; TRAP holds, addr=pc, rw=1, until reset.
- IDX: dummy read at {00,operand}; base←(operand+idx) mod 256.
  - ZPG_X_Y → EXEC.
  - ZPG_X_IND → PLO.
- PLO: read {00,ptr} → lo, where ptr = base (X_IND) or operand (IND_Y). Next PHI.
- PHI: read {00,(ptr+1) mod 256} → hi; zero-page wrap is mandatory. Next:
  - X_IND → EXEC.
  - IND_Y → FIX or EXEC (page rule below).
- ADH: read pc → hi, pc++. Next:
  - ABS_JMP: pc←{data_in,operand} → FETCH (3 cycles total).
  - ABS → EXEC.
  - ABS_X_Y → FIX or EXEC (page rule below).
- Indexed EA:
  - EA = {hi, lo+idx}; carry c = bit 8 of lo+idx.
  - Go to FIX if c=1 or to_mem=1; otherwise straight to EXEC.
- FIX: dummy read at {hi, (lo+idx)[7:0]}; hi←hi+c. Next EXEC.
- EXEC: addr=EA, rw=~to_mem, exec=1 → FETCH.
- Cycle counts (FETCH to FETCH):
  - IMPL/IMM 2; ZPG 3; ZPG_X 4; ABS 4.
  - ABS_X_Y read 4, or 5 on page cross; store 5.
  - ZPG_X_IND 6.
  - ZPG_IND_Y read 5, or 6 on page cross; store 6.
- BR: dummy read at pc; pc[7:0]←pc[7:0]+operand (operand signed).
  - If the high byte must change → BFIX, else FETCH.
  - Taken branch: 3 cycles; 4 on page cross.
- BFIX: dummy read at {pc_hi, new_lo}; pc_hi ±1 by sign/carry → FETCH.
- pc wraps FFFF→0000 without error.
- Reset asserted mid-instruction aborts immediately; the restart is VEC_LO.

Test Plan:
- Reset vector: mem[FFFC]=00, mem[FFFD]=80 → VEC_LO, VEC_HI, then FETCH at 8000 with sync=1 in cycle 3.
- ABS,X read: LDA 12F0,X with X=20 → EA 1310; FIX cycle reads 1210; exec at 1310; 5 cycles. With X=01 → EA 12F1, 4 cycles, no FIX.
- ZPG_X_IND wrap: operand FF, X=00 → pointer bytes read at 00FF and 0000; the EA is the bytes read there; exec rw follows to_mem.
- Store and stall: STA (IND),Y with to_mem=1, no page cross → 6 cycles, rw=0 only in EXEC. rdy=0 for 3 cycles mid-sequence → addr held, total +3.
- Branch at 80FD, operand 05, taken → pc 8104 via BFIX (4 cycles). Operand F0, not taken → 2 cycles, pc 80FF.
- Invalid mode: adr_mode=`ADR_INVAL → inval=1 in T1, state frozen in TRAP; rst_n pulse clears it and restarts at VEC_LO.
